// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_TRAP  = 3'd0,
        SEL_HOLD  = 3'd1,
        SEL_REDIR = 3'd2,
        SEL_PEND  = 3'd3,
        SEL_SEQ   = 3'd4
    } pc_sel_e;

    localparam logic [31:0] PC_RESET_VEC = 32'h8000_0000;
    localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority encoder: picks the PC source and flags a
// misaligned redirect target at the moment it would be applied.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  pc_state_e        state_i,
    input  logic             trap_valid_i,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             pend_valid_i,
    input  logic [XLEN-1:0]  pend_pc_i,
    input  logic             fetch_ready_i,
    output pc_sel_e          sel_c_o,
    output logic             misalign_c_o,
    output logic [XLEN-1:0]  target_c_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    logic target_bad;

    // A fresh redirect always overrides whatever is pending.
    assign target_c_o = redirect_valid_i ? redirect_pc_i : pend_pc_i;
    assign target_bad = |(target_c_o & ALIGN_MASK);

    always_comb begin
        sel_c_o      = SEL_HOLD;
        misalign_c_o = 1'b0;
        if (trap_valid_i) begin
            sel_c_o = SEL_TRAP;
        end else if (state_i == RUN && !stall_i) begin
            if (redirect_valid_i || pend_valid_i) begin
                if (target_bad) begin
                    misalign_c_o = 1'b1;
                end else begin
                    sel_c_o = redirect_valid_i ? SEL_REDIR : SEL_PEND;
                end
            end else if (fetch_ready_i) begin
                sel_c_o = SEL_SEQ;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, redirects with a
// stall-time pending slot, trap vectors, and halt on misaligned targets.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_RESET_VEC),
    parameter int unsigned     INC        = PC_INC,
    parameter int unsigned     ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             fetch_ready_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             trap_valid_i,
    input  logic [XLEN-1:0]  trap_vec_i,
    output logic             fetch_valid_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pcplus_o,
    output logic             redirect_pending_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr_o
);

    localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcplus_q, pcplus_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            fv_q, fv_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    pc_sel_e         sel_c;
    logic            misalign_c;
    logic [XLEN-1:0] target_c;

    pc_next_sel #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_sel (
        .state_i          (state_q),
        .trap_valid_i     (trap_valid_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pend_valid_i     (pend_q),
        .pend_pc_i        (pend_pc_q),
        .fetch_ready_i    (fetch_ready_i),
        .sel_c_o          (sel_c),
        .misalign_c_o     (misalign_c),
        .target_c_o       (target_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VEC;
            pcplus_q  <= RESET_VEC + INC_W;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            fv_q      <= 1'b0;
            mis_q     <= 1'b0;
            maddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pcplus_q  <= pcplus_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            fv_q      <= fv_d;
            mis_q     <= mis_d;
            maddr_q   <= maddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        mis_d     = 1'b0;
        maddr_d   = maddr_q;

        case (sel_c)
            SEL_TRAP:            pc_d = trap_vec_i;
            SEL_REDIR, SEL_PEND: pc_d = target_c;
            SEL_SEQ:             pc_d = pc_q + INC_W;
            default:             pc_d = pc_q;
        endcase
        pcplus_d = pc_d + INC_W;

        // Pending slot: consumed by any applied target, refilled only while stalled in RUN.
        if (sel_c == SEL_TRAP || sel_c == SEL_REDIR || sel_c == SEL_PEND || misalign_c) begin
            pend_d = 1'b0;
        end else if (state_q == RUN && stall_i && redirect_valid_i) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc_i;
        end

        if (misalign_c) begin
            mis_d   = 1'b1;
            maddr_d = target_c;
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (misalign_c) state_d = HALT;
            HALT:    if (trap_valid_i) state_d = RUN;
            default: state_d = BOOT;
        endcase

        fv_d = (state_d == RUN);
    end

    assign fetch_valid_o      = fv_q;
    assign pc_o               = pc_q;
    assign pcplus_o           = pcplus_q;
    assign redirect_pending_o = pend_q;
    assign misalign_o         = mis_q;
    assign misalign_addr_o    = maddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, reset-mid-stall sequence, then
// randomized traffic compared against a behavioural fetch-PC model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        fetch_ready_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_vec_i = 32'h0;
    logic        fetch_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pcplus_o;
    logic        redirect_pending_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    pc_gen dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall_i),
        .fetch_ready_i      (fetch_ready_i),
        .redirect_valid_i   (redirect_valid_i),
        .redirect_pc_i      (redirect_pc_i),
        .trap_valid_i       (trap_valid_i),
        .trap_vec_i         (trap_vec_i),
        .fetch_valid_o      (fetch_valid_o),
        .pc_o               (pc_o),
        .pcplus_o           (pcplus_o),
        .redirect_pending_o (redirect_pending_o),
        .misalign_o         (misalign_o),
        .misalign_addr_o    (misalign_addr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: mode flags, current PC, one pending redirect slot.
    logic [31:0] m_pc, m_pend_pc, m_maddr;
    logic        m_boot, m_halt, m_pend, m_mis;

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_pend = 1'b0; m_pend_pc = 32'h0;
        m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0; m_maddr = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        m_mis = 1'b0;
        if (trap_valid_i) begin
            m_pc = trap_vec_i; m_pend = 1'b0; m_boot = 1'b0; m_halt = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halt) begin
            if (stall_i) begin
                if (redirect_valid_i) begin m_pend = 1'b1; m_pend_pc = redirect_pc_i; end
            end else if (redirect_valid_i || m_pend) begin
                tgt = redirect_valid_i ? redirect_pc_i : m_pend_pc;
                m_pend = 1'b0;
                if ((tgt % 4) != 0) begin
                    m_mis = 1'b1; m_maddr = tgt; m_halt = 1'b1;
                end else begin
                    m_pc = tgt;
                end
            end else if (fetch_ready_i) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, " pc"}, pc_o, m_pc);
        chk({tag, " pcplus"}, pcplus_o, m_pc + 32'd4);
        chk({tag, " fv"}, 32'(fetch_valid_o), 32'(!m_boot && !m_halt));
        chk({tag, " pend"}, 32'(redirect_pending_o), 32'(m_pend));
        chk({tag, " mis"}, 32'(misalign_o), 32'(m_mis));
        chk({tag, " maddr"}, misalign_addr_o, m_maddr);
    endtask

    // Drive inputs at a negedge, clock once, advance the model, land on the next negedge.
    task automatic apply(input logic s, input logic r, input logic rv, input logic [31:0] rpc,
                         input logic tv, input logic [31:0] tvec);
        stall_i = s; fetch_ready_i = r; redirect_valid_i = rv; redirect_pc_i = rpc;
        trap_valid_i = tv; trap_vec_i = tvec;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic        s, r, rv;
        logic [31:0] rpc;
        logic        tv;
        logic [31:0] tvec;
        logic [31:0] e_pc;
        logic        e_fv, e_pend, e_mis;
        logic [31:0] e_maddr;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic rv, input logic [31:0] rpc,
                                input logic tv, input logic [31:0] tvec, input logic [31:0] e_pc,
                                input logic e_fv, input logic e_pend, input logic e_mis,
                                input logic [31:0] e_maddr);
        vec_t v;
        v.s = s; v.r = r; v.rv = rv; v.rpc = rpc; v.tv = tv; v.tvec = tvec;
        v.e_pc = e_pc; v.e_fv = e_fv; v.e_pend = e_pend; v.e_mis = e_mis; v.e_maddr = e_maddr;
        return v;
    endfunction

    localparam int NV = 22;
    localparam logic [31:0] Z = 32'h0;
    localparam logic O = 1'b1;
    localparam logic N = 1'b0;
    vec_t tbl [NV];

    initial begin
        tbl[0]  = mk(N, O, N, Z,            N, Z,            32'h8000_0000, O, N, N, Z);
        tbl[1]  = mk(N, O, N, Z,            N, Z,            32'h8000_0004, O, N, N, Z);
        tbl[2]  = mk(N, O, N, Z,            N, Z,            32'h8000_0008, O, N, N, Z);
        tbl[3]  = mk(O, O, O, 32'h8000_0100, N, Z,           32'h8000_0008, O, O, N, Z);
        tbl[4]  = mk(O, O, O, 32'h8000_0200, N, Z,           32'h8000_0008, O, O, N, Z);
        tbl[5]  = mk(O, O, N, Z,            N, Z,            32'h8000_0008, O, O, N, Z);
        tbl[6]  = mk(N, O, N, Z,            N, Z,            32'h8000_0200, O, N, N, Z);
        tbl[7]  = mk(N, O, N, Z,            N, Z,            32'h8000_0204, O, N, N, Z);
        tbl[8]  = mk(O, N, O, 32'h8000_0300, N, Z,           32'h8000_0204, O, O, N, Z);
        tbl[9]  = mk(O, N, N, Z,            O, 32'h0000_1000, 32'h0000_1000, O, N, N, Z);
        tbl[10] = mk(N, O, N, Z,            N, Z,            32'h0000_1004, O, N, N, Z);
        tbl[11] = mk(N, O, O, 32'h8000_0102, N, Z,           32'h0000_1004, N, N, O, 32'h8000_0102);
        tbl[12] = mk(N, O, O, 32'h8000_0400, N, Z,           32'h0000_1004, N, N, N, 32'h8000_0102);
        tbl[13] = mk(N, N, N, Z,            O, 32'h0000_2000, 32'h0000_2000, O, N, N, 32'h8000_0102);
        tbl[14] = mk(N, O, N, Z,            N, Z,            32'h0000_2004, O, N, N, 32'h8000_0102);
        tbl[15] = mk(N, O, N, Z,            O, 32'hFFFF_FFFC, 32'hFFFF_FFFC, O, N, N, 32'h8000_0102);
        tbl[16] = mk(N, O, N, Z,            N, Z,            32'h0000_0000, O, N, N, 32'h8000_0102);
        tbl[17] = mk(N, O, O, 32'h8000_0010, N, Z,           32'h8000_0010, O, N, N, 32'h8000_0102);
        tbl[18] = mk(N, N, N, Z,            N, Z,            32'h8000_0010, O, N, N, 32'h8000_0102);
        tbl[19] = mk(O, O, O, 32'h8000_0021, N, Z,           32'h8000_0010, O, O, N, 32'h8000_0102);
        tbl[20] = mk(N, O, N, Z,            N, Z,            32'h8000_0010, N, N, O, 32'h8000_0021);
        tbl[21] = mk(N, O, N, Z,            O, 32'h0000_0040, 32'h0000_0040, O, N, N, 32'h8000_0021);

        // Reset state while rst is held.
        #12;
        chk("rst pc", pc_o, 32'h8000_0000);
        chk("rst pcplus", pcplus_o, 32'h8000_0004);
        chk("rst fv", 32'(fetch_valid_o), 32'h0);
        chk("rst pend", 32'(redirect_pending_o), 32'h0);
        chk("rst mis", 32'(misalign_o), 32'h0);
        chk("rst maddr", misalign_addr_o, 32'h0);

        @(negedge clk);
        rst = 1'b0; fetch_ready_i = 1'b1;
        model_reset();
        #1;
        chk("boot fv", 32'(fetch_valid_o), 32'h0);
        chk("boot pc", pc_o, 32'h8000_0000);
        @(negedge clk);
        // The negedge above already passed one posedge; redo from a fresh reset for exact alignment.
        rst = 1'b1; #1; rst = 1'b0; model_reset();

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].s, tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].tv, tbl[i].tvec);
            chk($sformatf("row%0d pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("row%0d pcplus", i), pcplus_o, tbl[i].e_pc + 32'd4);
            chk($sformatf("row%0d fv", i), 32'(fetch_valid_o), 32'(tbl[i].e_fv));
            chk($sformatf("row%0d pend", i), 32'(redirect_pending_o), 32'(tbl[i].e_pend));
            chk($sformatf("row%0d mis", i), 32'(misalign_o), 32'(tbl[i].e_mis));
            chk($sformatf("row%0d maddr", i), misalign_addr_o, tbl[i].e_maddr);
        end

        // Reset asserted mid-stall with a redirect pending takes effect immediately.
        apply(O, O, O, 32'h8000_0500, N, Z);
        chk("midrst pend before", 32'(redirect_pending_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst pc", pc_o, 32'h8000_0000);
        chk("midrst pcplus", pcplus_o, 32'h8000_0004);
        chk("midrst pend", 32'(redirect_pending_o), 32'h0);
        chk("midrst fv", 32'(fetch_valid_o), 32'h0);
        @(negedge clk);
        stall_i = 1'b0; redirect_valid_i = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst boot fv", 32'(fetch_valid_o), 32'h0);
        @(negedge clk);
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        apply(N, O, N, Z, N, Z);
        model_cmp("post-rst");
        apply(N, O, N, Z, N, Z);
        model_cmp("post-rst2");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic        s, r, rv, tv;
            logic [31:0] rpc, tvec;
            s    = ($urandom_range(0, 3) == 0);
            r    = ($urandom_range(0, 3) != 0);
            rv   = ($urandom_range(0, 4) == 0);
            tv   = ($urandom_range(0, 19) == 0);
            rpc  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            tvec = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            apply(s, r, rv, rpc, tv, tvec);
            model_cmp($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch program-counter generator for the RISC-V core. It holds the current fetch address and advances by a fixed increment only when instruction memory accepts the request. It takes branch/jump redirects and trap vectors, and remembers a redirect that arrives while the fetch stage is stalled. Misaligned redirect targets are detected, and the unit halts fetch until a trap vector is supplied.

Parameters:
XLEN, 32, address width in bits
RESET_VEC, 32'h8000_0000, PC value on reset (XLEN bits)
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, number of low target bits that must be zero (1 when compressed instructions are enabled)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  fetch stall; blocks sequential advance and redirect application
fetch_ready_i  in  1  instruction memory accepts the current request
redirect_valid_i  in  1  branch/jump redirect request (one-cycle pulse)
redirect_pc_i  in  XLEN  redirect target
trap_valid_i  in  1  trap/flush request (one-cycle pulse); ignores stall
trap_vec_i  in  XLEN  trap vector
fetch_valid_o  out  1  fetch request valid at pc_o
pc_o  out  XLEN  current fetch PC
pcplus_o  out  XLEN  pc_o + INC, registered
redirect_pending_o  out  1  a redirect is latched and waiting for stall release
misalign_o  out  1  one-cycle pulse: rejected misaligned redirect
misalign_addr_o  out  XLEN  offending target, held until the next misalign event or reset

Behaviour:
- Reset (async, any state):
  - pc_o=RESET_VEC, pcplus_o=RESET_VEC+INC, state=BOOT.
  - fetch_valid_o=0, redirect_pending_o=0, misalign_o=0, misalign_addr_o=0.
  - Any pending redirect is discarded.
- State BOOT: lasts exactly one cycle after rst deasserts, with fetch_valid_o=0. Then go to RUN. Redirects are ignored in BOOT; a trap is applied.
- State RUN:
  - fetch_valid_o=1.
  - Next-PC priority, highest first:
    1. trap_valid_i: pc<=trap_vec_i, clear pending; applied even when stall_i=1.
    2. stall_i=1: hold pc. If redirect_valid_i, latch redirect_pc_i into the pending register; a newer redirect overwrites an older one.
    3. redirect_valid_i (not stalled): pc<=redirect_pc_i; this overrides any pending redirect.
    4. Pending redirect (not stalled): pc<=pending target, clear pending.
    5. fetch_ready_i=1: pc<=pc+INC.
    6. Otherwise hold pc.
  - Redirect with fetch_ready_i in the same cycle: the redirect wins and there is no increment.
- Misalignment:
  - A redirect target (direct or pending) whose low ALIGN_BITS bits are not all zero is not loaded into pc.
  - At the cycle it would have been applied: misalign_o pulses for one cycle, misalign_addr_o<=target, pending is cleared, state goes to HALT.
  - The check happens at application time, not at latch time.
  - Trap vectors are not checked.
- State HALT:
  - fetch_valid_o=0; pc holds.
  - Redirects are ignored and not latched.
  - trap_valid_i loads pc<=trap_vec_i and returns to RUN on the next cycle.
- Arithmetic: pc+INC is computed modulo 2^XLEN and wraps silently (e.g. 32'hFFFF_FFFC+4 -> 0). pcplus_o is always updated together with pc_o, so pcplus_o == pc_o+INC every cycle.
- Latency: one cycle from any accepted event to the new pc_o. redirect_pending_o is asserted in the cycle after latching and drops in the cycle the new pc appears.

Decomposition:
- Package pc_pkg:
  - pc_state_e enum {BOOT, RUN, HALT}.
  - Default RESET_VEC and INC constants.
  - next-PC select enum {SEL_TRAP, SEL_HOLD, SEL_REDIR, SEL_PEND, SEL_SEQ}.
- One sub-module, pc_next_sel: combinational priority encoder that produces the select and the misalign flag from the inputs, state and pending register. All registers, the FSM and the pending register live in pc_gen.

Test Plan:
- Reset release, fetch_ready_i=1 -> BOOT cycle with fetch_valid_o=0 and pc_o=8000_0000; then pc_o = 8000_0000, 8000_0004, 8000_0008 with pcplus_o one INC ahead.
- stall_i=1 for 3 cycles, redirect 8000_0100 in the 1st stalled cycle and 8000_0200 in the 2nd -> pc holds, redirect_pending_o=1; first cycle after stall drops, pc_o=8000_0200 and pending clears.
- Trap 0000_1000 while stall_i=1 with a pending redirect -> next cycle pc_o=0000_1000, pending cleared.
- Redirect 8000_0102, ALIGN_BITS=2 -> misalign_o pulses once, misalign_addr_o=8000_0102, fetch_valid_o=0 and pc unchanged; a later redirect is ignored; trap 0000_2000 -> pc_o=0000_2000, RUN resumes.
- Load pc=FFFF_FFFC via trap, fetch_ready_i=1 -> pc_o=0000_0000, pcplus_o=0000_0004.
- rst asserted mid-stall with a pending redirect -> immediately pc_o=8000_0000, redirect_pending_o=0, fetch_valid_o=0.
